// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_t               : controller FSM state encoding (2 bits)
//   REG_ADDR_WIDTH_DFLT   : default register index width
//   CNT_WIDTH_DFLT        : default stall counter width
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH_DFLT = 5;
  localparam int CNT_WIDTH_DFLT      = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush strobes of the pipeline controller.
//   master : pipeline side, drives hazard status, receives strobes + counter
//   slave  : controller side (pipeline_ctrl)
interface pipeline_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DFLT
);

  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_use_rs1;
  logic                      id_use_rs2;
  logic                      ex_mem_read;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_branch_taken;
  logic                      imem_ready;
  logic                      dmem_req;
  logic                      dmem_ready;
  logic                      mdu_start;
  logic                      mdu_done;

  logic                      pc_stall;
  logic                      if_id_stall;
  logic                      id_ex_stall;
  logic                      ex_mem_stall;
  logic                      if_id_flush;
  logic                      id_ex_flush;
  logic                      ex_mem_flush;
  logic                      mem_wb_flush;
  logic [CNT_WIDTH-1:0]      stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, imem_ready, dmem_req, dmem_ready, mdu_start, mdu_done,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, imem_ready, dmem_req, dmem_ready, mdu_start, mdu_done,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the EX instruction is a load whose destination
// (non-zero) is read by the instruction in ID.
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2 : ID source registers and read flags
//   ex_mem_read, ex_rd                   : EX load flag and destination
//   load_use                             : hazard present this cycle
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load to it never creates a dependency.
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipeline_ctrl_if.slave -- hazard inputs in, per-stage
//              stall/flush strobes and saturating stall_cycles counter out
// Priority each cycle: reset, memory wait, MDU wait, branch, load-use,
// fetch wait. Strobes are Mealy (state + current inputs).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DFLT,
  parameter int CNT_WIDTH      = CNT_WIDTH_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  state_t               state_q;
  state_t               state_d;
  logic                 load_use;
  logic                 mem_wait;
  logic                 mdu_wait;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic pc_stall;
  logic if_id_stall;
  logic id_ex_stall;
  logic ex_mem_stall;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .load_use    (load_use)
  );

  // MEM_WAIT is treated as RUN for the MDU check: the cycle the memory
  // completes is re-evaluated from the MDU row down.
  always_comb begin
    mem_wait = bus.dmem_req && !bus.dmem_ready;
    if (state_q == ST_MDU_WAIT)
      mdu_wait = !bus.mdu_done;
    else
      mdu_wait = bus.mdu_start && !bus.mdu_done;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    if (mem_wait)
      state_d = ST_MEM_WAIT;
    else if (mdu_wait)
      state_d = ST_MDU_WAIT;
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst) begin
      // all strobes held low
    end else if (mem_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mdu_wait) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // The ID instruction is on the wrong path, so a load-use stall on it is moot.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (!bus.imem_ready) begin
      pc_stall     = 1'b1;
      if_id_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (pc_stall && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.if_id_stall  = if_id_stall;
  assign bus.id_ex_stall  = id_ex_stall;
  assign bus.ex_mem_stall = ex_mem_stall;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl. Main instance uses a 32-bit counter;
// a second instance with a 4-bit counter covers saturation.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) ifc ();
  pipeline_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  ifc4 ();

  pipeline_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  pipeline_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (ifc4)
  );

  // Strobe order: pc, if_id, id_ex, ex_mem stalls | if_id, id_ex, ex_mem, mem_wb flushes
  localparam logic [7:0] S_NONE = 8'b0000_0000;
  localparam logic [7:0] S_MEM  = 8'b1111_0001;
  localparam logic [7:0] S_MDU  = 8'b1110_0010;
  localparam logic [7:0] S_BR   = 8'b0000_1100;
  localparam logic [7:0] S_LU   = 8'b1100_0100;
  localparam logic [7:0] S_FW   = 8'b1000_1000;

  function automatic logic [7:0] strb();
    return {ifc.pc_stall, ifc.if_id_stall, ifc.id_ex_stall, ifc.ex_mem_stall,
            ifc.if_id_flush, ifc.id_ex_flush, ifc.ex_mem_flush, ifc.mem_wb_flush};
  endfunction

  task automatic idle();
    ifc.id_rs1 = '0;  ifc.id_rs2 = '0;  ifc.id_use_rs1 = 0;  ifc.id_use_rs2 = 0;
    ifc.ex_mem_read = 0;  ifc.ex_rd = '0;  ifc.ex_branch_taken = 0;
    ifc.imem_ready = 1;  ifc.dmem_req = 0;  ifc.dmem_ready = 0;
    ifc.mdu_start = 0;  ifc.mdu_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    ifc.dmem_req = 1;
    ifc.dmem_ready = 0;
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL reset_strobes: got %b want %b", strb(), S_NONE);
    end
    tick();
    checks++;
    if (dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_RUN);
    end
    checks++;
    if (ifc.stall_cycles !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", ifc.stall_cycles);
    end
    rst = 0;
    idle();
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL idle_strobes: got %b want %b", strb(), S_NONE);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ifc.ex_mem_read = 1; ifc.ex_rd = 5'd5; ifc.id_rs1 = 5'd5; ifc.id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_LU) begin
      errors++; $display("FAIL lu_rs1: got %b want %b", strb(), S_LU);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL lu_after: got %b want %b", strb(), S_NONE);
    end
    checks++;
    if (ifc.stall_cycles !== 32'd1) begin
      errors++; $display("FAIL lu_cnt: got %0d want 1", ifc.stall_cycles);
    end
    tick();
    ifc.ex_mem_read = 1; ifc.ex_rd = 5'd0; ifc.id_rs1 = 5'd0; ifc.id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL lu_x0: got %b want %b", strb(), S_NONE);
    end
    tick();
    idle();
    ifc.ex_mem_read = 1; ifc.ex_rd = 5'd7; ifc.id_rs2 = 5'd7; ifc.id_use_rs2 = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_LU) begin
      errors++; $display("FAIL lu_rs2: got %b want %b", strb(), S_LU);
    end
    tick();
    idle();
    ifc.ex_mem_read = 1; ifc.ex_rd = 5'd7; ifc.id_rs1 = 5'd7; ifc.id_use_rs1 = 0;
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL lu_unused: got %b want %b", strb(), S_NONE);
    end
    checks++;
    if (ifc.stall_cycles !== 32'd2) begin
      errors++; $display("FAIL lu_cnt2: got %0d want 2", ifc.stall_cycles);
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    ifc.ex_mem_read = 1; ifc.ex_rd = 5'd5; ifc.id_rs1 = 5'd5; ifc.id_use_rs1 = 1;
    ifc.ex_branch_taken = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_BR) begin
      errors++; $display("FAIL br_over_lu: got %b want %b", strb(), S_BR);
    end
    tick();
    idle();
    ifc.ex_branch_taken = 1; ifc.imem_ready = 0;
    @(negedge clk);
    checks++;
    if (strb() !== S_BR) begin
      errors++; $display("FAIL br_over_fetch: got %b want %b", strb(), S_BR);
    end
    tick();
    checks++;
    if (ifc.stall_cycles !== 32'd2) begin
      errors++; $display("FAIL br_cnt: got %0d want 2", ifc.stall_cycles);
    end
  endtask

  task automatic test_fetch_wait();
    idle();
    ifc.imem_ready = 0;
    @(negedge clk);
    checks++;
    if (strb() !== S_FW) begin
      errors++; $display("FAIL fetch_wait: got %b want %b", strb(), S_FW);
    end
    tick();
    checks++;
    if (ifc.stall_cycles !== 32'd3) begin
      errors++; $display("FAIL fw_cnt: got %0d want 3", ifc.stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    idle();
    ifc.dmem_req = 1; ifc.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (strb() !== S_MEM) begin
        errors++; $display("FAIL mem_wait_%0d: got %b want %b", i, strb(), S_MEM);
      end
      tick();
      checks++;
      if (dut.state_q !== ST_MEM_WAIT) begin
        errors++; $display("FAIL mem_state_%0d: got %0d want %0d", i, dut.state_q, ST_MEM_WAIT);
      end
    end
    ifc.dmem_ready = 1; ifc.ex_branch_taken = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_BR) begin
      errors++; $display("FAIL mem_done_br: got %b want %b", strb(), S_BR);
    end
    tick();
    checks++;
    if (dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL mem_return: got %0d want %0d", dut.state_q, ST_RUN);
    end
    checks++;
    if (ifc.stall_cycles !== 32'd6) begin
      errors++; $display("FAIL mem_cnt: got %0d want 6", ifc.stall_cycles);
    end
  endtask

  task automatic test_mdu();
    idle();
    for (int i = 0; i < 4; i++) begin
      ifc.mdu_start = (i == 0);
      @(negedge clk);
      checks++;
      if (strb() !== S_MDU) begin
        errors++; $display("FAIL mdu_wait_%0d: got %b want %b", i, strb(), S_MDU);
      end
      tick();
      checks++;
      if (dut.state_q !== ST_MDU_WAIT) begin
        errors++; $display("FAIL mdu_state_%0d: got %0d want %0d", i, dut.state_q, ST_MDU_WAIT);
      end
    end
    ifc.mdu_done = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL mdu_done: got %b want %b", strb(), S_NONE);
    end
    tick();
    checks++;
    if (dut.state_q !== ST_RUN || ifc.stall_cycles !== 32'd10) begin
      errors++; $display("FAIL mdu_end: got state %0d cnt %0d want state 0 cnt 10",
                         dut.state_q, ifc.stall_cycles);
    end
    // start and done together: no stall
    ifc.mdu_start = 1; ifc.mdu_done = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL mdu_same_cycle: got %b want %b", strb(), S_NONE);
    end
    tick();
    // memory miss during MDU_WAIT takes priority
    ifc.mdu_start = 1; ifc.mdu_done = 0;
    tick();
    ifc.mdu_start = 0; ifc.dmem_req = 1; ifc.dmem_ready = 0;
    @(negedge clk);
    checks++;
    if (strb() !== S_MEM) begin
      errors++; $display("FAIL mdu_mem_prio: got %b want %b", strb(), S_MEM);
    end
    tick();
    checks++;
    if (dut.state_q !== ST_MEM_WAIT) begin
      errors++; $display("FAIL mdu_mem_state: got %0d want %0d", dut.state_q, ST_MEM_WAIT);
    end
    ifc.dmem_ready = 1; ifc.mdu_start = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_MDU) begin
      errors++; $display("FAIL mem_to_mdu: got %b want %b", strb(), S_MDU);
    end
    tick();
    ifc.dmem_req = 0; ifc.mdu_start = 0; ifc.mdu_done = 1;
    tick();
    checks++;
    if (dut.state_q !== ST_RUN || ifc.stall_cycles !== 32'd13) begin
      errors++; $display("FAIL mdu_mem_end: got state %0d cnt %0d want state 0 cnt 13",
                         dut.state_q, ifc.stall_cycles);
    end
  endtask

  task automatic test_reset_mid_wait();
    idle();
    ifc.dmem_req = 1; ifc.dmem_ready = 0;
    tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL rst_mid_strobes: got %b want %b", strb(), S_NONE);
    end
    tick();
    rst = 0;
    idle();
    checks++;
    if (dut.state_q !== ST_RUN || ifc.stall_cycles !== 32'd0) begin
      errors++; $display("FAIL rst_mid_state: got state %0d cnt %0d want state 0 cnt 0",
                         dut.state_q, ifc.stall_cycles);
    end
    @(negedge clk);
    checks++;
    if (strb() !== S_NONE) begin
      errors++; $display("FAIL rst_mid_after: got %b want %b", strb(), S_NONE);
    end
    tick();
  endtask

  task automatic test_saturation();
    ifc4.imem_ready = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ifc4.pc_stall !== 1'b1) begin
        errors++; $display("FAIL sat_stall_%0d: got %b want 1", i, ifc4.pc_stall);
      end
      tick();
      checks++;
      if (ifc4.stall_cycles !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
        errors++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, ifc4.stall_cycles,
                           (i + 1 > 15) ? 15 : i + 1);
      end
    end
    ifc4.imem_ready = 1;
    tick();
    checks++;
    if (ifc4.stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_hold: got %0d want 15", ifc4.stall_cycles);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    ifc4.id_rs1 = '0;  ifc4.id_rs2 = '0;  ifc4.id_use_rs1 = 0;  ifc4.id_use_rs2 = 0;
    ifc4.ex_mem_read = 0;  ifc4.ex_rd = '0;  ifc4.ex_branch_taken = 0;
    ifc4.imem_ready = 1;  ifc4.dmem_req = 0;  ifc4.dmem_ready = 0;
    ifc4.mdu_start = 0;  ifc4.mdu_done = 0;
    repeat (2) tick();
    test_reset();
    test_load_use();
    test_branch();
    test_fetch_wait();
    test_mem_wait();
    test_mdu();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage integer pipeline. Combines load-use hazard detection, taken-branch redirects, instruction-fetch wait, data-memory wait and multi-cycle MDU (mul/div) occupancy into per-stage `stall` and `flush` strobes. These strobes drive the `stall` inputs and bubble-insert (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register. Also keeps a saturating stall-cycle performance counter.

## Interface
- `REG_ADDR_WIDTH`, 5: register index width.
- `CNT_WIDTH`, 32: stall counter width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_WIDTH  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction actually reads rs1/rs2.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `ex_rd`  in  REG_ADDR_WIDTH  destination of the EX instruction.
- `ex_branch_taken`  in  1  the EX instruction redirects the PC this cycle.
- `imem_ready`  in  1  instruction memory returns valid data this cycle.
- `dmem_req`, `dmem_ready`  in  1  a MEM-stage access is pending / it completes this cycle.
- `mdu_start`, `mdu_done`  in  1  the EX instruction is multi-cycle / the MDU result is valid this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1  hold the register.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1  load a bubble (NOP) into the register.
- `stall_cycles`  out  CNT_WIDTH  count of cycles with `pc_stall`=1.

## Operation
- FSM states: RUN, MEM_WAIT, MDU_WAIT. Reset state is RUN.
- Strobes are Mealy outputs: they are a function of the state and the current inputs, so a condition stalls in the same cycle it appears.
- The following priority is evaluated every cycle; the first matching row defines all outputs, and any output not named is 0.
  1. `rst`=1: all strobes 0.
  2. Memory wait: `dmem_req`=1 and `dmem_ready`=0, in any state.
     - Assert `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` and `mem_wb_flush`.
     - Next state is MEM_WAIT.
  3. MDU wait: MDU_WAIT with `mdu_done`=0, or RUN with `mdu_start`=1 and `mdu_done`=0.
     - Assert `pc_stall`, `if_id_stall`, `id_ex_stall` and `ex_mem_flush`.
     - Next state is MDU_WAIT.
  4. Branch: `ex_branch_taken`=1.
     - Assert `if_id_flush` and `id_ex_flush`.
     - `pc_stall`=0, so the PC loads the branch target. The branch overrides a load-use hazard, because that instruction is on the wrong path.
  5. Load-use: `ex_mem_read`=1, `ex_rd`≠0, and either (`id_use_rs1` and `id_rs1`=`ex_rd`) or (`id_use_rs2` and `id_rs2`=`ex_rd`).
     - Assert `pc_stall`, `if_id_stall` and `id_ex_flush`.
  6. Fetch wait: `imem_ready`=0.
     - Assert `pc_stall` and `if_id_flush`.
  7. Otherwise all strobes are 0.
- State return:
  - MEM_WAIT returns to RUN in the cycle `dmem_ready`=1. That cycle is evaluated from row 3 down as RUN.
  - MDU_WAIT returns to RUN in the cycle `mdu_done`=1. That cycle is evaluated from row 4 down.
- A given register never has stall and flush asserted together.
- `stall_cycles` increments at each edge where `pc_stall`=1 and `rst`=0. It saturates at all-ones and does not wrap.

## Timing
- All outputs after reset: strobes 0, `stall_cycles`=0, state RUN.
- Reset asserted mid-MEM_WAIT or mid-MDU_WAIT: state is RUN at the next edge. No strobe is asserted while `rst`=1.
- Load-use costs exactly one bubble. In the following cycle the load has moved to MEM, so row 5 is false.
- A memory wait of N cycles with `dmem_ready`=0 gives N stall cycles. Pipeline registers update on the edge of the `dmem_ready`=1 cycle.
- MDU: `mdu_start` with `mdu_done` arriving K cycles later gives K stall cycles. If `mdu_start` and `mdu_done` are both 1 in the same cycle, there is no stall.
- Branch flush lasts 1 cycle and adds 0 stall cycles to the counter.

## Structure
- Shared package `pipeline_pkg`:
  - FSM state encoding constants `ST_RUN`, `ST_MEM_WAIT`, `ST_MDU_WAIT` (2 bits).
  - `REG_ADDR_WIDTH` default.
- One combinational sub-module, `hazard_detect`, computes the row-5 load-use compare and outputs `load_use`.
- FSM, priority logic and counter live in `pipeline_ctrl`.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1, others idle → exactly 1 cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1; `stall_cycles`=1. Repeat with `ex_rd`=0 → no stall.
- **Branch vs load-use:** load-use conditions plus `ex_branch_taken`=1 → `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0; counter unchanged.
- **Memory wait:** `dmem_req`=1, `dmem_ready` low for 3 cycles then high → 3 cycles with all four stalls and `mem_wb_flush` asserted, state MEM_WAIT, return to RUN; `stall_cycles`=3.
- **MDU:** `mdu_start` pulse, `mdu_done` 4 cycles later → 4 cycles of `pc_stall`/`if_id_stall`/`id_ex_stall`/`ex_mem_flush`. A `dmem_req` miss during MDU_WAIT → memory-wait strobes take priority and state becomes MEM_WAIT.
- **Reset mid-wait:** enter MEM_WAIT, assert `rst` for 1 cycle → all strobes 0 during `rst`, state RUN and `stall_cycles`=0 after.
- **Saturation:** `CNT_WIDTH`=4, hold `imem_ready`=0 for 20 cycles → `stall_cycles` reaches 15 and stays at 15.
